// File: rtl/mem_pkg.sv
// Shared constants and types for the banked memory responder.
// The optional macro ALIGN_CHECK_EN (used in banked_mem_responder) turns
// on the odd-byte-address check.
package mem_pkg;

    localparam int NUM_BANKS    = 4;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int RD_LATENCY   = 2;
    localparam int BUSY_CYCLES  = 4;
    localparam int BANK_SEL_LSB = 1;
    localparam int ROW_LSB      = 3;
    localparam int BUSY_CNT_W   = 4;

    typedef logic [1:0]                  bank_idx_t;
    typedef logic [ADDR_W-ROW_LSB-1:0]   row_t;
    typedef logic [DATA_W-1:0]           word_t;

endpackage

// File: rtl/mem_bank.sv
// One memory bank: word storage with synchronous write and registered read
// data, plus the counter that keeps the bank busy after each accept.
module mem_bank #(
    parameter int DATA_W      = 16,
    parameter int ROW_W       = 13,
    parameter int BUSY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);
    import mem_pkg::*;

    localparam logic [BUSY_CNT_W-1:0] CNT_LOAD = BUSY_CNT_W'(BUSY_CYCLES - 1);

    logic [DATA_W-1:0]     mem [2**ROW_W];
    logic [BUSY_CNT_W-1:0] cnt;

    assign busy = (cnt != '0);

    // Busy counter: an accept reloads it, otherwise it counts down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (we || re) begin
            cnt <= CNT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Storage: contents survive reset, read data is the first pipeline stage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[row] <= wdata;
        end
        if (re) begin
            rdata <= mem[row];
        end
    end

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved main memory answering the cache controller.
// Decodes err/stall, routes accepts to banks and returns reads in order
// with a fixed two-cycle latency.
// Optional macro ALIGN_CHECK_EN: odd byte addresses raise err and are dropped.
module banked_mem_responder #(
    parameter int NUM_BANKS   = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BUSY_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 err
);
    import mem_pkg::*;

    localparam int ROW_W = ADDR_W - ROW_LSB;

    logic              req;
    logic              accept;
    bank_idx_t         bank_sel;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    // Read return pipeline: p0 = bank output register, p1 = output register.
    logic              vld_p0;
    bank_idx_t         bank_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    assign req      = rd | wr;
    assign bank_sel = addr[BANK_SEL_LSB +: 2];
    assign row      = addr[ADDR_W-1:ROW_LSB];

`ifdef ALIGN_CHECK_EN
    assign err = (rd & wr) | (req & addr[0]);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
    assign err = rd & wr;
`endif

    assign stall  = req & ~err & busy[bank_sel];
    assign accept = req & ~err & ~stall;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel;
        assign sel = (bank_sel == bank_idx_t'(b));

        mem_bank #(
            .DATA_W      (DATA_W),
            .ROW_W       (ROW_W),
            .BUSY_CYCLES (BUSY_CYCLES)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (accept & wr & sel),
            .re    (accept & rd & sel),
            .row   (row),
            .wdata (data_in),
            .rdata (bank_rdata[b]),
            .busy  (busy[b])
        );
    end

    // Valid bits travel with the read; reset flushes anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= accept & rd;
            vld_p1 <= vld_p0;
        end
    end

    // Data side of the pipeline: remember the bank, then capture its word.
    always_ff @(posedge clk) begin
        bank_p0 <= bank_sel;
        data_p1 <= bank_rdata[bank_p0];
    end

    assign data_valid = vld_p1;
    assign data_out   = vld_p1 ? data_p1 : '0;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Bench for banked_mem_responder: directed steps followed by random traffic,
// all compared against a cycle-level reference model of the memory.
module tb_banked_mem_responder;

    localparam int BUSY = 4;
`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        stall;
    logic [3:0]  busy;
    logic [15:0] data_out;
    logic        data_valid;
    logic        err;

    banked_mem_responder #(
        .NUM_BANKS   (4),
        .ADDR_W      (16),
        .DATA_W      (16),
        .BUSY_CYCLES (BUSY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .stall      (stall),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
        bit          known;
    } rd_ret_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          free_at [4];
    logic [15:0] ref_mem [int];
    rd_ret_t     ret_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check against the model, advance the model.
    task automatic step(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic rn);
        logic       req, e_err, e_stall, e_dv, acc;
        logic [3:0] e_busy;
        logic [15:0] e_dout;
        int         b, key;
        rd_ret_t    ent;
        rd = r; wr = w; addr = a; data_in = d; rst = rn;
        #1;
        if (!rn) begin
            ret_q.delete();
            for (int i = 0; i < 4; i++) free_at[i] = 0;
        end
        req     = r | w;
        e_err   = (r & w) | (ALIGN & req & a[0]);
        b       = int'(a[2:1]);
        key     = int'(a[15:1]);
        for (int i = 0; i < 4; i++) e_busy[i] = (cyc < free_at[i]);
        e_stall = req & ~e_err & e_busy[b];
        e_dv    = (ret_q.size() > 0) && (ret_q[0].due == cyc);
        e_dout  = 16'h0;
        chk("err", 32'(err), 32'(e_err));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("data_valid", 32'(data_valid), 32'(e_dv));
        if (e_dv) begin
            ent = ret_q.pop_front();
            if (ent.known) chk("data_out", 32'(data_out), 32'(ent.data));
        end else begin
            chk("data_out_idle", 32'(data_out), 32'(e_dout));
        end
        acc = rn & req & ~e_err & ~e_stall;
        if (acc) begin
            free_at[b] = cyc + BUSY;
            if (w) ref_mem[key] = d;
            if (r) begin
                ent.due   = cyc + 2;
                ent.known = ref_mem.exists(key);
                ent.data  = ent.known ? ref_mem[key] : 16'h0;
                ret_q.push_back(ent);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
        @(negedge clk);

        // Reset held with a read request present.
        step(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0);
        idle(2);

        // Write then read back the same word.
        step(1'b0, 1'b1, 16'h0008, 16'hBEEF, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 16'h0008, 16'h0, 1'b1);
        idle(4);

        // Bank conflict: read to bank 0 held while the write keeps it busy.
        step(1'b0, 1'b1, 16'h0000, 16'h1234, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0008, 16'h0, 1'b1);
        idle(4);

        // Interleaved reads across all four banks on consecutive cycles.
        step(1'b0, 1'b1, 16'h0002, 16'hA002, 1'b1);
        step(1'b0, 1'b1, 16'h0004, 16'hA004, 1'b1);
        step(1'b0, 1'b1, 16'h0006, 16'hA006, 1'b1);
        idle(4);
        step(1'b1, 1'b0, 16'h0000, 16'h0, 1'b1);
        step(1'b1, 1'b0, 16'h0002, 16'h0, 1'b1);
        step(1'b1, 1'b0, 16'h0004, 16'h0, 1'b1);
        step(1'b1, 1'b0, 16'h0006, 16'h0, 1'b1);
        idle(4);

        // Illegal requests: rd and wr together, then an odd address.
        step(1'b1, 1'b1, 16'h0002, 16'h5555, 1'b1);
        idle(1);
        step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b1);
        idle(4);

        // Reset while a read is in flight; contents survive.
        step(1'b1, 1'b0, 16'h0004, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 16'h0004, 16'h0, 1'b1);
        idle(4);

        // Fill a small window, then random traffic over it.
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b1, 16'(i * 2), 16'($urandom), 1'b1);
        idle(4);
        for (int i = 0; i < 400; i++) begin
            int k;
            logic r, w;
            k = int'($urandom_range(0, 9));
            r = (k < 5) || (k == 9);
            w = (k >= 5);
            step(r, w, 16'($urandom_range(0, 63)), 16'($urandom), 1'b1);
        end
        idle(4);

        chk("queue_drained", 32'(ret_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
